// File: rtl/ocp_slave_mem.sv
// ocp_slave_mem: OCP slave target backed by an internal word array.
//
// Accepts one request beat per cycle (incrementing precise bursts included) after a
// programmable accept stall, commits writes at the accept edge and returns responses
// in order through a fixed-latency shift pipe.
//
// Ports:
//   Clk           OCP clock, all state on the rising edge
//   MReset_n      asynchronous active-low reset
//   MCmd          IDLE/WR/RD/RDEX/RDL/WRNP/WRC/BCST (3'b000..3'b111)
//   MAddr         byte address of the current beat
//   MData         write data
//   MBurstLength  beats in the burst, 0 treated as 1; sampled on the first beat only
//   MReqLast      master's final-beat marker, cross-checked against the beat counter
//   SCmdAccept    request beat accepted this cycle
//   SResp         NULL=00 DVA=01 FAIL=10 ERR=11
//   SData         read data, valid when SResp != NULL
//   SRespLast     response belongs to the burst's final beat
module ocp_slave_mem #(
  parameter int unsigned MADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_LSB    = 2,
  parameter int unsigned ACCEPT_WAIT = 0,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                   Clk,
  input  logic                   MReset_n,
  input  logic [2:0]             MCmd,
  input  logic [MADDR_WIDTH-1:0] MAddr,
  input  logic [DATA_WIDTH-1:0]  MData,
  input  logic [9:0]             MBurstLength,
  input  logic                   MReqLast,
  output logic                   SCmdAccept,
  output logic [1:0]             SResp,
  output logic [DATA_WIDTH-1:0]  SData,
  output logic                   SRespLast
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [3:0]  WaitLast = 4'(ACCEPT_WAIT - 1);

  localparam logic [2:0] CmdIdle = 3'b000;
  localparam logic [2:0] CmdWr   = 3'b001;
  localparam logic [2:0] CmdWrnp = 3'b101;
  localparam logic [2:0] CmdWrc  = 3'b110;
  localparam logic [2:0] CmdBcst = 3'b111;

  localparam logic [1:0] RespDva = 2'b01;
  localparam logic [1:0] RespErr = 2'b11;

  typedef enum logic [1:0] {StIdle, StWait, StAcc} state_e;

  typedef struct packed {
    logic [1:0]            resp;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } rsp_t;

  state_e          state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  logic [9:0]      beat_q, beat_d;
  logic [9:0]      len_m1_q, len_m1_d;
  rsp_t            pipe_q [RD_LATENCY];
  rsp_t            rsp_new;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic            cmd_active;
  logic            is_write;
  logic            is_posted;
  logic            take;
  logic            beat_last;
  logic            oor;
  logic            err;
  logic [9:0]      len_eff_m1;
  logic [9:0]      cur_len_m1;
  logic [IdxW-1:0] word_idx;
  logic            unused_addr_lsb;

  assign cmd_active = (MCmd != CmdIdle);
  assign is_write   = (MCmd == CmdWr) || (MCmd == CmdWrnp) || (MCmd == CmdWrc) ||
                      (MCmd == CmdBcst);
  assign is_posted  = (MCmd == CmdWr) || (MCmd == CmdBcst);

  // Burst length comes from the bus on the first beat, from the latched copy afterwards.
  assign len_eff_m1 = (MBurstLength == 10'd0) ? 10'd0 : MBurstLength - 10'd1;
  assign cur_len_m1 = (beat_q == 10'd0) ? len_eff_m1 : len_m1_q;
  assign beat_last  = (beat_q == cur_len_m1);

  // DEPTH is a power of two, so any set bit above the index field means out of range.
  assign word_idx        = MAddr[ADDR_LSB +: IdxW];
  assign oor             = |MAddr[MADDR_WIDTH-1:ADDR_LSB+IdxW];
  assign unused_addr_lsb = ^MAddr[ADDR_LSB-1:0];

  assign err  = oor || (MReqLast != beat_last);
  assign take = SCmdAccept;

  // Request FSM and accept strobe.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    SCmdAccept = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_active) begin
          if (ACCEPT_WAIT == 0) begin
            // No stall: idle behaves like the accept state.
            SCmdAccept = 1'b1;
            if (!beat_last) state_d = StAcc;
          end else if (ACCEPT_WAIT == 1) begin
            state_d = StAcc;
          end else begin
            // The first non-idle cycle counts as the first held cycle.
            state_d = StWait;
            wait_d  = 4'd1;
          end
        end
      end
      StWait: begin
        if (!cmd_active) begin
          state_d = StIdle;
        end else if (wait_q == WaitLast) begin
          state_d = StAcc;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StAcc: begin
        if (cmd_active) begin
          SCmdAccept = 1'b1;
          if (beat_last) state_d = StIdle;
        end else if (beat_q == 10'd0) begin
          // Master withdrew before any beat was taken; gaps inside a burst keep ACC.
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!MReset_n) SCmdAccept = 1'b0;
  end

  // Beat counter and latched burst length.
  always_comb begin
    beat_d   = beat_q;
    len_m1_d = len_m1_q;
    if (take) begin
      if (beat_q == 10'd0) len_m1_d = len_eff_m1;
      beat_d = beat_last ? 10'd0 : beat_q + 10'd1;
    end
  end

  // Response entering the pipe this cycle; NULL when nothing responds.
  always_comb begin
    rsp_new = '0;
    if (take && !is_posted) begin
      rsp_new.resp = err ? RespErr : RespDva;
      rsp_new.data = (err || is_write) ? '0 : mem_q[word_idx];
      rsp_new.last = beat_last;
    end
  end

  always_ff @(posedge Clk or negedge MReset_n) begin
    if (!MReset_n) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      beat_q   <= '0;
      len_m1_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      beat_q    <= beat_d;
      len_m1_q  <= len_m1_d;
      pipe_q[0] <= rsp_new;
      for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Storage has no reset; contents are undefined until written.
  always_ff @(posedge Clk) begin
    if (take && is_write && !oor) mem_q[word_idx] <= MData;
  end

  assign SResp     = pipe_q[RD_LATENCY-1].resp;
  assign SData     = pipe_q[RD_LATENCY-1].data;
  assign SRespLast = pipe_q[RD_LATENCY-1].last;

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Scoreboard bench for ocp_slave_mem: a no-stall instance (defaults) and a stalled
// instance (ACCEPT_WAIT=3, RD_LATENCY=3), each checked against its own reference memory.
module tb_ocp_slave_mem;

  localparam int MLat  = 1;
  localparam int SLat  = 3;
  localparam int SWait = 3;

  localparam logic [2:0] Wr = 3'd1, Rd = 3'd2, Wrnp = 3'd5, Wrc = 3'd6;

  typedef struct {
    logic [1:0] resp;
    logic [7:0] data;
    logic       last;
    int         due;
  } exp_t;

  logic        clk, rst_n;
  logic [2:0]  m_cmd, s_cmd;
  logic [63:0] m_addr, s_addr;
  logic [7:0]  m_data, s_data;
  logic [9:0]  m_len, s_len;
  logic        m_last, s_last;
  logic        m_acc, s_acc;
  logic [1:0]  m_resp, s_resp;
  logic [7:0]  m_sdata, s_sdata;
  logic        m_rlast, s_rlast;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  exp_t sb_q[$];
  exp_t sb2_q[$];
  logic [7:0] ref_mem [64];
  logic [7:0] s_mem [64];

  ocp_slave_mem u_dut (
    .Clk(clk), .MReset_n(rst_n), .MCmd(m_cmd), .MAddr(m_addr), .MData(m_data),
    .MBurstLength(m_len), .MReqLast(m_last), .SCmdAccept(m_acc), .SResp(m_resp),
    .SData(m_sdata), .SRespLast(m_rlast)
  );

  ocp_slave_mem #(.ACCEPT_WAIT(SWait), .RD_LATENCY(SLat)) u_stall (
    .Clk(clk), .MReset_n(rst_n), .MCmd(s_cmd), .MAddr(s_addr), .MData(s_data),
    .MBurstLength(s_len), .MReqLast(s_last), .SCmdAccept(s_acc), .SResp(s_resp),
    .SData(s_sdata), .SRespLast(s_rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: any non-NULL response must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (m_resp != 2'b00) begin
      if (sb_q.size() == 0) begin
        check("main_unexpected_resp", {62'd0, m_resp}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("main_resp", m_resp, e.resp);
        check("main_data", m_sdata, e.data);
        check("main_last", m_rlast, e.last);
        check("main_due_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon_stall
    exp_t e;
    if (s_resp != 2'b00) begin
      if (sb2_q.size() == 0) begin
        check("stall_unexpected_resp", {62'd0, s_resp}, 64'd0);
      end else begin
        e = sb2_q.pop_front();
        check("stall_resp", s_resp, e.resp);
        check("stall_data", s_sdata, e.data);
        check("stall_last", s_rlast, e.last);
        check("stall_due_cycle", cyc, e.due);
      end
    end
  end

  // Drives one burst on the no-stall instance. last_beat marks where MReqLast is raised;
  // stop_after>0 leaves the bus driven after that many accepted beats.
  task automatic m_burst(input logic [2:0] cmd, input logic [63:0] base, input logic [9:0] len,
                         input int last_beat, input logic [7:0] data0, input int stop_after);
    int n;
    n = (len == 10'd0) ? 1 : int'(len);
    for (int i = 0; i < n; i++) begin
      logic [63:0] a;
      logic [7:0]  d;
      logic        lf, cl, oor, isw, posted, err;
      int          waits;
      a = base + 64'(4 * i);
      d = data0 + 8'(i);
      lf = (i == last_beat);
      m_cmd = cmd; m_addr = a; m_data = d; m_last = lf;
      m_len = (i == 0) ? len : 10'($urandom_range(0, 1023));
      waits = 0;
      forever begin
        @(negedge clk);
        if (m_acc) break;
        waits++;
        if (waits > 20) break;
      end
      check("main_accept_wait", waits, 0);
      if (!m_acc) begin
        m_cmd = 3'd0;
        return;
      end
      @(posedge clk); #1;
      cl = (i == n - 1);
      oor = (a >> 2) >= 64;
      isw = (cmd == 3'd1) || (cmd == 3'd5) || (cmd == 3'd6) || (cmd == 3'd7);
      posted = (cmd == 3'd1) || (cmd == 3'd7);
      err = oor || (lf != cl);
      if (!posted)
        sb_q.push_back('{resp: err ? 2'b11 : 2'b01,
                         data: (err || isw) ? 8'd0 : ref_mem[a[7:2]],
                         last: cl, due: cyc + MLat - 1});
      if (isw && !oor) ref_mem[a[7:2]] = d;
      if (i + 1 == stop_after) return;
    end
    m_cmd = 3'd0;
  endtask

  // Well-formed burst on the stalled instance; first beat must wait SWait cycles.
  task automatic s_burst(input logic [2:0] cmd, input logic [63:0] base, input int n,
                         input logic [7:0] data0);
    for (int i = 0; i < n; i++) begin
      logic [63:0] a;
      logic [7:0]  d;
      logic        isw;
      int          waits;
      a = base + 64'(4 * i);
      d = data0 + 8'(i);
      s_cmd = cmd; s_addr = a; s_data = d; s_last = (i == n - 1);
      s_len = (i == 0) ? 10'(n) : 10'($urandom_range(0, 1023));
      waits = 0;
      forever begin
        @(negedge clk);
        if (s_acc) break;
        waits++;
        if (waits > 20) break;
      end
      check("stall_accept_wait", waits, (i == 0) ? SWait : 0);
      if (!s_acc) begin
        s_cmd = 3'd0;
        return;
      end
      @(posedge clk); #1;
      isw = (cmd == 3'd1) || (cmd == 3'd5) || (cmd == 3'd6) || (cmd == 3'd7);
      if (!(cmd == 3'd1 || cmd == 3'd7))
        sb2_q.push_back('{resp: 2'b01, data: isw ? 8'd0 : s_mem[a[7:2]],
                          last: (i == n - 1), due: cyc + SLat - 1});
      if (isw) s_mem[a[7:2]] = d;
    end
    s_cmd = 3'd0;
  endtask

  task automatic init_mem();
    for (int b = 0; b < 4; b++) m_burst(Wr, 64'(b * 64), 10'd16, 15, 8'($urandom), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    m_cmd = '0; m_addr = '0; m_data = '0; m_len = '0; m_last = 1'b0;
    s_cmd = '0; s_addr = '0; s_data = '0; s_len = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_accept", m_acc, 1'b0);
    check("reset_resp", m_resp, 2'b00);
    check("reset_sdata", m_sdata, 8'd0);
    check("reset_rlast", m_rlast, 1'b0);
    check("reset_stall_resp", s_resp, 2'b00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    init_mem();

    // Directed cases.
    m_burst(Wr, 64'h4, 10'd1, 0, 8'hFF, 0);
    m_burst(Rd, 64'h4, 10'd1, 0, 8'h00, 0);
    m_burst(Wr, 64'h0, 10'd4, 3, 8'h00, 0);
    m_burst(Rd, 64'h0, 10'd4, 3, 8'h00, 0);
    m_burst(Rd, 64'h400, 10'd1, 0, 8'h00, 0);
    m_burst(Rd, 64'h8000_0000_0000_0000, 10'd1, 0, 8'h00, 0);
    m_burst(Rd, 64'h10, 10'd2, 0, 8'h00, 0);
    m_burst(Rd, 64'h10, 10'd1, 0, 8'h00, 0);
    m_burst(Wrnp, 64'h8, 10'd1, 0, 8'h5A, 0);
    m_burst(Rd, 64'h8, 10'd1, 0, 8'h00, 0);
    m_burst(Wrc, 64'hC, 10'd0, 0, 8'h33, 0);
    m_burst(Rd, 64'hC, 10'd0, 0, 8'h00, 0);

    // Randomized bursts, some crossing or starting out of range, some with bad MReqLast.
    for (int k = 0; k < 60; k++) begin
      logic [2:0]  cmd;
      logic [9:0]  len;
      logic [63:0] base;
      int          n, lb;
      cmd = 3'($urandom_range(1, 7));
      len = 10'($urandom_range(0, 6));
      n = (len == 10'd0) ? 1 : int'(len);
      if ($urandom_range(0, 99) < 85) base = 64'($urandom_range(0, 63)) * 64'd4;
      else base = {$urandom, $urandom};
      lb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n)) : n - 1;
      m_burst(cmd, base, len, lb, 8'($urandom), 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // Reset in the middle of a 4-beat read, with MCmd still asserted.
    m_burst(Rd, 64'h0, 10'd4, 3, 8'h00, 2);
    rst_n = 1'b0;
    #1;
    check("midreset_accept", m_acc, 1'b0);
    check("midreset_resp", m_resp, 2'b00);
    check("midreset_sdata", m_sdata, 8'd0);
    check("midreset_rlast", m_rlast, 1'b0);
    sb_q.delete();
    m_cmd = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    init_mem();
    m_burst(Rd, 64'h4, 10'd1, 0, 8'h00, 0);

    // Stalled instance: accept timing, burst streaming, abort, non-posted write.
    s_burst(Wr, 64'h0, 3, 8'hA0);
    @(posedge clk); #1;
    s_burst(Rd, 64'h0, 3, 8'h00);
    s_cmd = Rd; s_addr = 64'h0; s_len = 10'd1; s_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stall_abort_noaccept", s_acc, 1'b0);
    end
    @(posedge clk); #1;
    s_cmd = 3'd0;
    @(posedge clk); #1;
    s_burst(Rd, 64'h0, 1, 8'h00);
    s_burst(Wrnp, 64'h20, 1, 8'hC3);
    s_burst(Rd, 64'h20, 1, 8'h00);

    m_cmd = 3'd0;
    s_cmd = 3'd0;
    repeat (10) @(posedge clk);
    #1;
    check("main_sb_drained", sb_q.size(), 0);
    check("stall_sb_drained", sb2_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
